decoder_scan_ctrl: RTL and testbench

Sequencer for the 4-to-16 LED decoder built from two 2-to-4 decoder stages. Drives the decoder's enable and 4-bit address so a single lit LED scans up, down or ping-pong at a prescaled rate. Supports start/stop/clear control and single-step while paused. Sits between board buttons/switches (already debounced and synchronised upstream) and the decoder.

---
 rtl/decoder_scan_ctrl.sv | 73 +++++++
 tb/tb_decoder_scan_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: drives a 4-to-16 LED decoder so one lit LED scans up, down or ping-pong at a prescaled rate
module decoder_scan_ctrl #(
  parameter int PRESCALE = 4,
  parameter int CNT_W = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       step,
  input  logic [1:0] mode,
  output logic       en,
  output logic [3:0] a,
  output logic       busy,
  output logic       wrap
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] pre, pre_n;
  logic [3:0] a_n, adv_a;
  logic dn, dn_n, adv_dn, adv_w, wrap_n, load, run_go, tick, adv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pre <= '0;
      a <= '0;
      dn <= 1'b0;
      en <= 1'b0;
      busy <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      pre <= pre_n;
      a <= a_n;
      dn <= dn_n;
      en <= state_n != IDLE;
      busy <= state_n == RUN;
      wrap <= wrap_n;
    end
  end
  always_comb begin
    state_n = clear ? IDLE :
              stop  ? (state == RUN ? PAUSE : state) :
              start ? RUN : state;
  end
  // dn records the last sweep direction so ping-pong resumes where up/down left off
  always_comb begin
    adv_a = a;
    adv_dn = dn;
    adv_w = 1'b0;
    case (mode)
      2'b00: begin adv_a = a + 4'd1; adv_dn = 1'b0; adv_w = a == 4'd15; end
      2'b01: begin adv_a = a - 4'd1; adv_dn = 1'b1; adv_w = a == 4'd0; end
      2'b10: begin
        adv_w = dn ? a == 4'd0 : a == 4'd15;
        adv_dn = adv_w ? !dn : dn;
        adv_a = (dn ^ adv_w) ? a - 4'd1 : a + 4'd1;
      end
      default: ;
    endcase
  end
  always_comb begin
    load = state == IDLE && start && !stop && !clear;
    run_go = state == RUN && !stop && !clear;
    tick = pre == CNT_W'(PRESCALE - 1);
    adv = (run_go && tick) || (state == PAUSE && step && !start && !stop && !clear);
    pre_n = (clear || load) ? '0 : run_go ? (tick ? '0 : pre + 1'b1) : pre;
    a_n = load ? (mode == 2'b01 ? 4'd15 : 4'd0) : adv ? adv_a : a;
    dn_n = load ? mode == 2'b01 : adv ? adv_dn : dn;
    wrap_n = adv && adv_w;
  end
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: directed checks of scan, pause/step, priority and async reset
module tb_decoder_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, step = 1'b0;
  logic [1:0] mode = 2'b00;
  logic en, busy, wrap;
  logic [3:0] a;
  int total = 0, bad = 0;
  decoder_scan_ctrl #(.PRESCALE(4), .CNT_W(26)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .step(step), .mode(mode), .en(en), .a(a), .busy(busy), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic e_en, input logic [3:0] e_a, input logic e_busy, input logic e_wrap);
    chk({tag, ".en"}, 32'(en), 32'(e_en));
    chk({tag, ".a"}, 32'(a), 32'(e_a));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
  endtask
  initial begin
    #3 chk_all("in_reset", 0, 0, 0, 0);
    #20 rst_n = 1'b1;
    cyc(3);
    chk_all("idle", 0, 0, 0, 0);
    start = 1'b1; cyc(1); start = 1'b0;
    chk_all("up_enter", 1, 0, 1, 0);
    cyc(3); chk("up_pre3", 32'(a), 0);
    cyc(1); chk("up_first", 32'(a), 1);
    cyc(56); chk_all("up_at15", 1, 15, 1, 0);
    cyc(3); chk("up_before_wrap", 32'(a), 15);
    cyc(1); chk_all("up_wrap", 1, 0, 1, 1);
    cyc(1); chk("up_wrap_1cyc", 32'(wrap), 0);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk_all("clear", 0, 0, 0, 0);
    mode = 2'b10; start = 1'b1; cyc(1); start = 1'b0;
    cyc(60); chk_all("pp_at15", 1, 15, 1, 0);
    cyc(4); chk_all("pp_turn_top", 1, 14, 1, 1);
    cyc(1); chk("pp_turn_top_1cyc", 32'(wrap), 0);
    cyc(3); chk("pp_13", 32'(a), 13);
    cyc(48); chk("pp_1", 32'(a), 1);
    cyc(4); chk_all("pp_0", 1, 0, 1, 0);
    cyc(4); chk_all("pp_turn_bot", 1, 1, 1, 1);
    cyc(32); chk("pp_9", 32'(a), 9);
    mode = 2'b01;
    cyc(4); chk_all("pp_to_down", 1, 8, 1, 0);
    cyc(12); chk("down_5", 32'(a), 5);
    cyc(1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk_all("pause", 1, 5, 0, 0);
    mode = 2'b00;
    step = 1'b1; cyc(1); step = 1'b0; chk("step1", 32'(a), 6);
    cyc(1); chk("step_hold", 32'(a), 6);
    step = 1'b1; cyc(1); step = 1'b0; chk("step2", 32'(a), 7);
    step = 1'b1; cyc(1); step = 1'b0; chk("step3", 32'(a), 8);
    start = 1'b1; cyc(1); start = 1'b0;
    chk_all("resume", 1, 8, 1, 0);
    cyc(2); chk("resume_wait", 32'(a), 8);
    cyc(1); chk("resume_adv", 32'(a), 9);
    step = 1'b1; cyc(1); step = 1'b0; chk("step_in_run", 32'(a), 9);
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    chk_all("start_stop", 1, 9, 0, 0);
    clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
    chk_all("clear_start", 0, 9, 0, 0);
    step = 1'b1; cyc(1); step = 1'b0; chk_all("step_in_idle", 0, 9, 0, 0);
    mode = 2'b11; start = 1'b1; cyc(1); start = 1'b0;
    chk_all("hold_enter", 1, 0, 1, 0);
    cyc(16); chk_all("hold_run", 1, 0, 1, 0);
    clear = 1'b1; cyc(1); clear = 1'b0;
    mode = 2'b01; start = 1'b1; cyc(1); start = 1'b0;
    chk_all("down_load", 1, 15, 1, 0);
    cyc(4); chk("down_14", 32'(a), 14);
    cyc(56); chk_all("down_0", 1, 0, 1, 0);
    cyc(4); chk_all("down_wrap", 1, 15, 1, 1);
    cyc(16); chk_all("down_11", 1, 11, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    cyc(5); chk_all("post_rst_idle", 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
